// File: rtl/trail_collision_check_if.sv
// Signal bundle between the game controller / trail grid read ports and the
// collision checker. The master side is whoever drives requests and returns
// grid read data (controller plus memories); the slave side is the checker.
interface trail_collision_check_if;
  logic        check;
  logic [9:0]  new_x1;
  logic [9:0]  new_y1;
  logic [9:0]  new_x2;
  logic [9:0]  new_y2;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic        rd_data1;
  logic        rd_data2;
  logic        busy;
  logic        done;
  logic        crash1;
  logic        crash2;

  modport master (
    output check, new_x1, new_y1, new_x2, new_y2, rd_data1, rd_data2,
    input  rd_en, rd_addr, busy, done, crash1, crash2
  );

  modport slave (
    input  check, new_x1, new_y1, new_x2, new_y2, rd_data1, rd_data2,
    output rd_en, rd_addr, busy, done, crash1, crash2
  );
endinterface

// File: rtl/trail_collision_check.sv
// Light-cycle collision checker: reads both trail grids at the two next head
// cells, flags out-of-bounds and head-on meetings, and reports per-player
// crash results with a single done pulse.
module trail_collision_check #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CELL_SHIFT = 2,
  parameter int ROW_STRIDE = 399,
  parameter int RD_LAT     = 1
) (
  input logic                    clock,
  input logic                    reset,
  trail_collision_check_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WAIT, DONE} state_t;

  localparam logic [9:0]  X_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]  Y_LIM     = 10'(V_ACTIVE);
  localparam logic [16:0] STRIDE    = 17'(ROW_STRIDE);
  localparam logic [1:0]  WAIT_INIT = 2'(RD_LAT - 1);

  // Flattened cell address; terms widened to 17 bits, product truncated.
  function automatic logic [16:0] cell_addr(input logic [9:0] cx, input logic [9:0] cy);
    return ({7'd0, cy} * STRIDE) + {7'd0, cx};
  endfunction

  state_t      state;
  logic        rd_en_reg;
  logic [16:0] rd_addr_reg;
  logic        rd_player_reg;   // 0 while slot 1 is on the bus, 1 for slot 2
  logic        busy_reg;
  logic        done_reg;
  logic        crash1_reg;
  logic        crash2_reg;
  logic        oob1_reg;
  logic        oob2_reg;
  logic        head_on_reg;
  logic [16:0] addr2_reg;
  logic        hit1_reg;
  logic        hit2_reg;
  logic [1:0]  wait_cnt;

  // Slot tags travel alongside the memory read so returning data can be
  // attributed to the right player; a suppressed read carries valid=0.
  logic tag_valid [RD_LAT];
  logic tag_p2    [RD_LAT];

  logic [9:0]  cx1, cy1, cx2, cy2;
  logic        oob1_in, oob2_in, head_on_in;
  logic [16:0] a1_in, a2_in;
  logic        rd_hit, hit1_next, hit2_next;

  assign cx1 = bus.new_x1 >> CELL_SHIFT;
  assign cy1 = bus.new_y1 >> CELL_SHIFT;
  assign cx2 = bus.new_x2 >> CELL_SHIFT;
  assign cy2 = bus.new_y2 >> CELL_SHIFT;

  assign oob1_in    = (bus.new_x1 >= X_LIM) || (bus.new_y1 >= Y_LIM);
  assign oob2_in    = (bus.new_x2 >= X_LIM) || (bus.new_y2 >= Y_LIM);
  // Head-on is decided on cell coordinates, not on the flattened address,
  // so aliasing from address truncation cannot fake a meeting.
  assign head_on_in = (cx1 == cx2) && (cy1 == cy2);
  assign a1_in      = cell_addr(cx1, cy1);
  assign a2_in      = cell_addr(cx2, cy2);

  // Either grid holding a trail bit means the cell is taken, own trail included.
  assign rd_hit    = bus.rd_data1 | bus.rd_data2;
  assign hit1_next = (tag_valid[RD_LAT-1] && !tag_p2[RD_LAT-1]) ? rd_hit : hit1_reg;
  assign hit2_next = (tag_valid[RD_LAT-1] &&  tag_p2[RD_LAT-1]) ? rd_hit : hit2_reg;

  // Slot-tag shift register matched to the memory read latency.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // First stage samples the read currently presented to the memories.
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            tag_valid[0] <= 1'b0;
            tag_p2[0]    <= 1'b0;
          end else begin
            tag_valid[0] <= rd_en_reg;
            tag_p2[0]    <= rd_player_reg;
          end
        end
      end else begin : g_body
        // Later stages just delay the tag.
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            tag_valid[gi] <= 1'b0;
            tag_p2[gi]    <= 1'b0;
          end else begin
            tag_valid[gi] <= tag_valid[gi-1];
            tag_p2[gi]    <= tag_p2[gi-1];
          end
        end
      end
    end
  endgenerate

  // Control FSM with registered outputs and hit capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      rd_player_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      crash1_reg    <= 1'b0;
      crash2_reg    <= 1'b0;
      oob1_reg      <= 1'b0;
      oob2_reg      <= 1'b0;
      head_on_reg   <= 1'b0;
      addr2_reg     <= '0;
      hit1_reg      <= 1'b0;
      hit2_reg      <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      rd_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (state == IDLE) begin
        hit1_reg <= 1'b0;
        hit2_reg <= 1'b0;
      end else begin
        hit1_reg <= hit1_next;
        hit2_reg <= hit2_next;
      end
      case (state)
        IDLE: begin
          if (bus.check) begin
            oob1_reg      <= oob1_in;
            oob2_reg      <= oob2_in;
            head_on_reg   <= head_on_in;
            addr2_reg     <= a2_in;
            crash1_reg    <= 1'b0;
            crash2_reg    <= 1'b0;
            rd_addr_reg   <= a1_in;
            rd_en_reg     <= !oob1_in;
            rd_player_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state         <= RD1;
          end
        end
        RD1: begin
          rd_addr_reg   <= addr2_reg;
          rd_en_reg     <= !oob2_reg;
          rd_player_reg <= 1'b1;
          state         <= RD2;
        end
        RD2: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          // The last WAIT cycle is the one where slot 2 returns, so the
          // crash verdict uses the just-captured hit values.
          if (wait_cnt == 2'd0) begin
            done_reg   <= 1'b1;
            crash1_reg <= oob1_reg | hit1_next | head_on_reg;
            crash2_reg <= oob2_reg | hit2_next | head_on_reg;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en   = rd_en_reg;
  assign bus.rd_addr = rd_addr_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.crash1  = crash1_reg;
  assign bus.crash2  = crash2_reg;

endmodule
